// File: rtl/branch_predictor.sv
// branch_predictor: BTB with per-entry saturating direction counters and branch/mispredict statistics
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] next_pc_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic              invalidate_i,
  output logic              mispredict_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CNT_W-1:0]  r_cnt    [ENTRIES];
  logic [STAT_W-1:0] r_branch_cnt;
  logic [STAT_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_mispredict;
  logic             w_unused;

  assign w_idx     = pc_i[IDX_W+1:2];
  assign w_tag     = pc_i[ADDR_W-1:IDX_W+2];
  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && r_tag[w_upd_idx] == w_upd_tag;
  assign w_unused  = ^{pc_i[1:0], upd_pc_i[1:0]};

  // Zero-latency lookup of the fetch PC; reads pre-edge table contents
  always_comb begin
    hit_o        = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    pred_taken_o = hit_o && r_cnt[w_idx][CNT_W-1];
    next_pc_o    = pred_taken_o ? r_target[w_idx] : pc_i + ADDR_W'(4);
  end

  // Resolved branch disagrees with the direction or target predicted at fetch
  always_comb begin
    w_mispredict = upd_valid_i && (upd_pred_taken_i != upd_taken_i ||
                   (upd_taken_i && upd_pred_target_i != upd_target_i));
  end

  assign mispredict_o  = w_mispredict;
  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

  // Table training; invalidate wins over a same-cycle update
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else if (start_i) begin
      if (invalidate_i) begin
        for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
      end else if (upd_valid_i) begin
        if (w_upd_hit && upd_taken_i) begin
          r_cnt[w_upd_idx]    <= &r_cnt[w_upd_idx] ? r_cnt[w_upd_idx] : r_cnt[w_upd_idx] + CNT_W'(1);
          r_target[w_upd_idx] <= upd_target_i;
        end else if (w_upd_hit) begin
          r_cnt[w_upd_idx]    <= |r_cnt[w_upd_idx] ? r_cnt[w_upd_idx] - CNT_W'(1) : r_cnt[w_upd_idx];
        end else if (upd_taken_i) begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= upd_target_i;
          r_cnt[w_upd_idx]    <= CNT_W'(1) << (CNT_W - 1);
        end
      end
    end
  end

  // Saturating statistics, counted even when the table update is suppressed by invalidate
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (start_i && upd_valid_i) begin
      if (!(&r_branch_cnt)) r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (w_mispredict && !(&r_mispred_cnt)) r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, invalidate, stats and reset
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pt = 1'b0;
  logic [31:0] upd_ptgt = '0;
  logic        inval = 1'b0;

  logic        hit0, pt0, mis0, hit1, pt1, mis1;
  logic [31:0] npc0, npc1;
  logic [15:0] bc0, mc0;
  logic [1:0]  bc1, mc1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor u0 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .pc_i(pc),
    .hit_o(hit0), .pred_taken_o(pt0), .next_pc_o(npc0),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pt), .upd_pred_target_i(upd_ptgt),
    .invalidate_i(inval), .mispredict_o(mis0), .branch_cnt_o(bc0), .mispred_cnt_o(mc0)
  );

  branch_predictor #(.STAT_W(2)) u1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .pc_i(pc),
    .hit_o(hit1), .pred_taken_o(pt1), .next_pc_o(npc1),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pt), .upd_pred_target_i(upd_ptgt),
    .invalidate_i(inval), .mispredict_o(mis1), .branch_cnt_o(bc1), .mispred_cnt_o(mc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptg);
    upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tgt; upd_pt = ptk; upd_ptgt = ptg;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    upd_valid = 1'b0; inval = 1'b0;
    #1;
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptg, input logic exp_mis);
    drive(p, t, tgt, ptk, ptg);
    chk("mispredict", {31'd0, mis0}, {31'd0, exp_mis});
    tick();
  endtask

  task automatic look(input string tag, input logic [31:0] p, input logic h, input logic t, input logic [31:0] n);
    pc = p; #1;
    chk({tag, ".hit"}, {31'd0, hit0}, {31'd0, h});
    chk({tag, ".taken"}, {31'd0, pt0}, {31'd0, t});
    chk({tag, ".next"}, npc0, n);
  endtask

  initial begin
    #1;
    look("rst_0x100", 32'h100, 1'b0, 1'b0, 32'h104);
    look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    chk("rst_bc", {16'd0, bc0}, 32'd0);
    chk("rst_mc", {16'd0, mc0}, 32'd0);
    #1 rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;

    pc = 32'h100;
    drive(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("alloc_mis", {31'd0, mis0}, 32'd1);
    chk("alloc_readold", {31'd0, hit0}, 32'd0);
    tick();
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h40);
    chk("alloc_bc", {16'd0, bc0}, 32'd1);
    chk("alloc_mc", {16'd0, mc0}, 32'd1);
    chk("idle_mis", {31'd0, mis0}, 32'd0);

    drive(32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    chk("nt1_mis", {31'd0, mis0}, 32'd1);
    chk("nt1_readold", {31'd0, pt0}, 32'd1);
    tick();
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("nt3", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h48);
    upd(32'h100, 1'b1, 32'h48, 1'b1, 32'h48, 1'b0);
    upd(32'h100, 1'b1, 32'h48, 1'b1, 32'h40, 1'b1);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("sat3", 32'h100, 1'b1, 1'b1, 32'h48);
    chk("train_bc", {16'd0, bc0}, 32'd9);
    chk("train_mc", {16'd0, mc0}, 32'd5);
    chk("sat2_bc", {30'd0, bc1}, 32'd3);
    chk("sat2_mc", {30'd0, mc1}, 32'd3);

    look("alias_miss", 32'h200, 1'b0, 1'b0, 32'h204);
    upd(32'h200, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h80);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    upd(32'h104, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    look("idx1", 32'h104, 1'b1, 1'b1, 32'h300);

    start = 1'b0;
    inval = 1'b1;
    upd(32'h100, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
    look("hold_upd", 32'h100, 1'b0, 1'b0, 32'h104);
    look("hold_inval", 32'h200, 1'b1, 1'b1, 32'h80);
    chk("hold_bc", {16'd0, bc0}, 32'd11);
    chk("hold_mc", {16'd0, mc0}, 32'd7);
    start = 1'b1;

    inval = 1'b1;
    upd(32'h100, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
    look("inv_100", 32'h100, 1'b0, 1'b0, 32'h104);
    look("inv_200", 32'h200, 1'b0, 1'b0, 32'h204);
    look("inv_104", 32'h104, 1'b0, 1'b0, 32'h108);
    chk("inv_bc", {16'd0, bc0}, 32'd12);
    chk("inv_mc", {16'd0, mc0}, 32'd8);

    upd(32'h200, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    look("pre_rst", 32'h200, 1'b1, 1'b1, 32'h80);
    rst_n = 1'b0; #1;
    look("async_rst", 32'h200, 1'b0, 1'b0, 32'h204);
    chk("async_bc", {16'd0, bc0}, 32'd0);
    chk("async_mc", {16'd0, mc0}, 32'd0);
    chk("async_bc2", {30'd0, bc1}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) upd(32'h300, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    chk("stat_bc", {16'd0, bc0}, 32'd5);
    chk("stat_mc", {16'd0, mc0}, 32'd5);
    chk("stat2_bc", {30'd0, bc1}, 32'd3);
    chk("stat2_mc", {30'd0, mc1}, 32'd3);
    look("post_rst", 32'h300, 1'b1, 1'b1, 32'h400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters.
- Sits beside PC/instruction fetch in the 5-stage pipeline.
- Predicts the next fetch PC combinationally from the current PC.
- Trained at clock edges by resolved branches from the ID-stage branch unit, so taken branches no longer always cost an IF/ID flush.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- ADDR_W, 32, PC width in bits.
- ENTRIES, 64, number of BTB entries. Power of two, >= 2. IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width. >= 1.
- STAT_W, 16, width of each statistics counter.
- Derived, not overridable: TAG_W = ADDR_W - IDX_W - 2.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: reset, asynchronous, active-low.
- start_i, input, 1: run enable. Training and statistics are frozen while low.
- pc_i, input, ADDR_W: current fetch PC.
- hit_o, output, 1: valid entry with matching tag for pc_i.
- pred_taken_o, output, 1: predicted taken.
- next_pc_o, output, ADDR_W: predicted next fetch PC.
- upd_valid_i, input, 1: a branch resolved this cycle.
- upd_pc_i, input, ADDR_W: PC of the resolved branch.
- upd_taken_i, input, 1: actual outcome.
- upd_target_i, input, ADDR_W: actual target.
- upd_pred_taken_i, input, 1: prediction made for this branch at fetch, carried down the pipe.
- upd_pred_target_i, input, ADDR_W: predicted target carried down the pipe.
- invalidate_i, input, 1: clear all valid bits.
- mispredict_o, output, 1: combinational mispredict flag for the current update.
- branch_cnt_o, output, STAT_W: resolved branch count.
- mispred_cnt_o, output, STAT_W: mispredict count.

Behaviour:
- Addressing: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Storage per entry: valid, tag, target (ADDR_W), cnt (CNT_W).
- Reset (rst_i low, asynchronous): all valid = 0, all cnt = 0, all targets/tags = 0, both statistics counters = 0.
- Outputs during/after reset: hit_o = 0, pred_taken_o = 0, next_pc_o = pc_i + 4.
- Lookup (combinational, zero latency):
  - hit_o = valid[idx] && tag[idx] == tag(pc_i).
  - pred_taken_o = hit_o && cnt[idx][CNT_W-1].
  - next_pc_o = pred_taken_o ? target[idx] : pc_i + 4, computed modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
- mispredict_o = upd_valid_i && (upd_pred_taken_i != upd_taken_i || (upd_taken_i && upd_pred_target_i != upd_target_i)).
- Training (rising edge, when start_i && upd_valid_i && !invalidate_i), indexed by upd_pc_i:
  - Hit, taken: cnt = min(cnt + 1, 2^CNT_W - 1); target = upd_target_i.
  - Hit, not taken: cnt = max(cnt - 1, 0). Target unchanged; entry stays valid.
  - Miss, taken: allocate and overwrite any aliased entry. valid = 1, tag written, target = upd_target_i, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- invalidate_i (rising edge, when start_i): all valid = 0. Has priority over training in the same cycle. Counters and targets are left stale.
- Statistics (rising edge, when start_i && upd_valid_i, regardless of invalidate_i):
  - branch_cnt_o += 1.
  - mispred_cnt_o += 1 if mispredict_o.
  - Both saturate at 2^STAT_W - 1. Cleared only by reset.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-edge contents (read-old). The new state is visible from the next cycle.
- start_i low: lookups still operate. Training, invalidate and statistics hold.
- Reset asserted mid-operation: state clears immediately without waiting for a clock edge. Training resumes on the first edge after release with start_i high.

Test Plan:
- Reset, then pc_i = 0x100 -> hit_o = 0, pred_taken_o = 0, next_pc_o = 0x104. pc_i = 0xFFFFFFFC -> next_pc_o = 0x00000000.
- Update upd_pc_i = 0x100, taken, target 0x40, pred_taken = 0 -> mispredict_o = 1 that cycle. Next cycle pc_i = 0x100 -> hit 1, taken 1, next_pc_o = 0x40. branch_cnt = 1, mispred_cnt = 1.
- From cnt = 2 on 0x100:
  - not-taken ×3 -> cnt 1, 0, 0; pred_taken_o = 0 after the first; next_pc_o = 0x104.
  - then taken ×3 -> cnt 1, 2, 3; pred_taken_o = 1 from the second.
  - 4th taken -> cnt stays 3.
- Aliasing with ENTRIES = 64: 0x100 and 0x200 share idx 0.
  - 0x100 valid, lookup 0x200 -> hit_o = 0.
  - Taken update 0x200 -> target 0x80 -> 0x200 hits with next_pc 0x80; 0x100 now misses.
- invalidate_i and a taken update in the same cycle -> all lookups miss next cycle; branch_cnt still increments.
- Statistics saturation with STAT_W = 2: 5 mispredicting updates -> both counters read 3.
- start_i = 0 with an update -> no change to entries or counters.
- rst_i pulsed low between edges -> counters read 0 and hit_o = 0 before the next edge.
